// File: rtl/ni_packetizer_if.sv
// node_pkg / node_port: flit types and the flit/enable/ack link between a
// source and a node input port.
//   node_pkg  : addr_t, flit_type_e, payload_t, control_hdr_t, flit_t
//   node_port : flit, enable (source -> node), ack (node -> source)
//               modport up   : the sending side
//               modport down : the receiving side
package node_pkg;

    typedef struct packed {
        logic [1:0] x;
        logic [1:0] y;
    } addr_t;

    typedef enum logic [1:0] {
        HEADER = 2'd0,
        BODY   = 2'd1,
        TAIL   = 2'd2
    } flit_type_e;

    typedef logic [15:0] payload_t;

    typedef struct packed {
        addr_t      dst_addr;
        addr_t      src_addr;
        logic [7:0] rsvd;
    } control_hdr_t;

    typedef struct packed {
        flit_type_e flit_type;
        payload_t   payload;
    } flit_t;

endpackage

interface node_port;
    node_pkg::flit_t flit;
    logic            enable;
    logic            ack;

    modport up   (output flit, output enable, input ack);
    modport down (input flit, input enable, output ack);
endinterface

// File: rtl/ni_packetizer.sv
// ni_packetizer: turns a message (destination + up to MAX_BODY words) into a
// HEADER / BODY... / TAIL flit sequence on a node_port.up link.
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   msg_valid    message offered
//   msg_ready    message can be accepted (IDLE only)
//   msg_dst      destination node address
//   msg_len      number of BODY flits, clamped to MAX_BODY
//   msg_data     body words, word k in bits [k*PW +: PW]
//   port         flit/enable out, ack in
//   pkt_sent     one-cycle pulse after a TAIL flit is accepted
//   err_self     one-cycle pulse after a self-addressed message is dropped
//   busy         high while not in IDLE
module ni_packetizer #(
    parameter int  SRC_X    = 1,
    parameter int  SRC_Y    = 1,
    parameter int  MAX_BODY = 4,
    localparam int PW       = $bits(node_pkg::payload_t),
    localparam int LW       = $clog2(MAX_BODY + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   msg_valid,
    output logic                   msg_ready,
    input  node_pkg::addr_t        msg_dst,
    input  logic [LW-1:0]          msg_len,
    input  logic [MAX_BODY*PW-1:0] msg_data,
    node_port.up                   port,
    output logic                   pkt_sent,
    output logic                   err_self,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAD = 2'd1,
        BODY = 2'd2,
        TAIL = 2'd3
    } state_e;

    localparam logic [1:0]    SRC_X_A = 2'(SRC_X);
    localparam logic [1:0]    SRC_Y_A = 2'(SRC_Y);
    localparam logic [LW-1:0] MAX_L   = LW'(MAX_BODY);

    state_e                 state_q, state_d;
    logic [LW-1:0]          idx_q, idx_d;
    logic [LW-1:0]          len_q, len_d;
    node_pkg::addr_t        dst_q, dst_d;
    logic [MAX_BODY*PW-1:0] data_q, data_d;
    logic                   pkt_sent_q, pkt_sent_d;
    logic                   err_self_q, err_self_d;

    logic [LW-1:0]          len_clamped;
    node_pkg::payload_t     body_word;
    node_pkg::control_hdr_t hdr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            len_q      <= '0;
            dst_q      <= '0;
            data_q     <= '0;
            pkt_sent_q <= 1'b0;
            err_self_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            dst_q      <= dst_d;
            data_q     <= data_d;
            pkt_sent_q <= pkt_sent_d;
            err_self_q <= err_self_d;
        end
    end

    assign len_clamped = (msg_len > MAX_L) ? MAX_L : msg_len;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        len_d      = len_q;
        dst_d      = dst_q;
        data_d     = data_q;
        pkt_sent_d = 1'b0;
        err_self_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (msg_valid) begin
                    dst_d  = msg_dst;
                    data_d = msg_data;
                    len_d  = len_clamped;
                    idx_d  = '0;
                    if (msg_dst.x == SRC_X_A && msg_dst.y == SRC_Y_A) begin
                        err_self_d = 1'b1;
                    end else begin
                        state_d = HEAD;
                    end
                end
            end
            HEAD: begin
                if (port.ack) begin
                    idx_d   = '0;
                    state_d = (len_q != '0) ? BODY : TAIL;
                end
            end
            BODY: begin
                if (port.ack) begin
                    if (idx_q == len_q - LW'(1)) begin
                        state_d = TAIL;
                    end else begin
                        idx_d = idx_q + LW'(1);
                    end
                end
            end
            TAIL: begin
                if (port.ack) begin
                    pkt_sent_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        body_word = '0;
        for (int unsigned k = 0; k < MAX_BODY; k++) begin
            if (idx_q == LW'(k)) begin
                body_word = data_q[k*PW +: PW];
            end
        end
    end

    // Outputs decode from registered state only, so ack never reaches them
    // combinationally. IDLE shows BODY/0 because the node looks at
    // flit_type even while enable is low.
    always_comb begin
        hdr          = '0;
        hdr.dst_addr = dst_q;
        port.enable  = (state_q != IDLE);
        port.flit    = '{flit_type: node_pkg::BODY, payload: '0};
        case (state_q)
            HEAD:    port.flit = '{flit_type: node_pkg::HEADER, payload: hdr};
            BODY:    port.flit = '{flit_type: node_pkg::BODY, payload: body_word};
            TAIL:    port.flit = '{flit_type: node_pkg::TAIL, payload: '0};
            default: port.flit = '{flit_type: node_pkg::BODY, payload: '0};
        endcase
    end

    assign msg_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign pkt_sent  = pkt_sent_q;
    assign err_self  = err_self_q;

endmodule

// File: tb/tb_ni_packetizer.sv
// Directed testbench for ni_packetizer (SRC=(1,1), MAX_BODY=4).
module tb_ni_packetizer;

    logic            clk;
    logic            rst;
    logic            msg_valid;
    logic            msg_ready;
    node_pkg::addr_t msg_dst;
    logic [2:0]      msg_len;
    logic [63:0]     msg_data;
    logic            pkt_sent;
    logic            err_self;
    logic            busy;

    int n_assert;
    int n_fail;

    node_port link ();

    ni_packetizer #(.SRC_X(1), .SRC_Y(1), .MAX_BODY(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .msg_valid (msg_valid),
        .msg_ready (msg_ready),
        .msg_dst   (msg_dst),
        .msg_len   (msg_len),
        .msg_data  (msg_data),
        .port      (link),
        .pkt_sent  (pkt_sent),
        .err_self  (err_self),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [1:0] T_H = 2'd0;
    localparam logic [1:0] T_B = 2'd1;
    localparam logic [1:0] T_T = 2'd2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_flit(input string tag, input logic en, input logic [1:0] ty,
                            input logic [15:0] pl);
        chk({tag, ".enable"}, 32'(link.enable), 32'(en));
        chk({tag, ".type"}, 32'(link.flit.flit_type), 32'(ty));
        chk({tag, ".payload"}, 32'(link.flit.payload), 32'(pl));
    endtask

    task automatic chk_idle(input string tag, input logic exp_sent);
        chk_flit(tag, 1'b0, T_B, 16'h0000);
        chk({tag, ".msg_ready"}, 32'(msg_ready), 32'd1);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".pkt_sent"}, 32'(pkt_sent), 32'(exp_sent));
    endtask

    task automatic offer(input logic [1:0] x, input logic [1:0] y, input logic [2:0] len,
                         input logic [63:0] data);
        msg_valid = 1'b1;
        msg_dst   = '{x: x, y: y};
        msg_len   = len;
        msg_data  = data;
    endtask

    // Header payload layout: dst.x[15:14], dst.y[13:12], everything else zero.
    function automatic logic [15:0] hdr(input int x, input int y);
        return 16'((x << 14) | (y << 12));
    endfunction

    logic [1:0]  bp_type [11];
    logic [15:0] bp_pl   [11];
    logic        bp_ack  [11];

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        msg_valid = 1'b0;
        msg_dst   = '0;
        msg_len   = '0;
        msg_data  = '0;
        link.ack  = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk_idle("reset", 1'b0);
        chk("reset.err_self", 32'(err_self), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk_idle("post_reset", 1'b0);

        // Basic packet: dst=(2,1), len=2, data {A,B}
        offer(2'd2, 2'd1, 3'd2, 64'h0000_0000_000B_000A);
        @(negedge clk);
        msg_valid = 1'b0;
        chk_flit("basic.hdr", 1'b1, T_H, hdr(2, 1));
        chk("basic.hdr.msg_ready", 32'(msg_ready), 32'd0);
        chk("basic.hdr.busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk_flit("basic.b0", 1'b1, T_B, 16'h000A);
        @(negedge clk);
        chk_flit("basic.b1", 1'b1, T_B, 16'h000B);
        @(negedge clk);
        chk_flit("basic.tail", 1'b1, T_T, 16'h0000);
        chk("basic.tail.pkt_sent", 32'(pkt_sent), 32'd0);
        @(negedge clk);
        chk_idle("basic.done", 1'b1);
        @(negedge clk);
        chk_idle("basic.after", 1'b0);

        // Zero-length packet: dst=(0,2)
        offer(2'd0, 2'd2, 3'd0, 64'h0000_0000_0000_1234);
        @(negedge clk);
        msg_valid = 1'b0;
        chk_flit("zero.hdr", 1'b1, T_H, hdr(0, 2));
        @(negedge clk);
        chk_flit("zero.tail", 1'b1, T_T, 16'h0000);
        @(negedge clk);
        chk_idle("zero.done", 1'b1);

        // Backpressure: len=3, 3 stall cycles on HEADER, 2 on BODY[1]
        bp_type = '{T_H, T_H, T_H, T_H, T_B, T_B, T_B, T_B, T_B, T_T, T_B};
        bp_pl   = '{hdr(3, 0), hdr(3, 0), hdr(3, 0), hdr(3, 0), 16'h0011, 16'h0022,
                    16'h0022, 16'h0022, 16'h0033, 16'h0000, 16'h0000};
        bp_ack  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        offer(2'd3, 2'd0, 3'd3, 64'h0000_0033_0022_0011);
        @(negedge clk);
        msg_valid = 1'b0;
        for (int c = 0; c < 11; c++) begin
            chk_flit($sformatf("bp.c%0d", c + 1), (c < 10), bp_type[c], bp_pl[c]);
            chk($sformatf("bp.c%0d.pkt_sent", c + 1), 32'(pkt_sent), 32'(c == 10));
            link.ack = bp_ack[c];
            @(negedge clk);
        end
        link.ack = 1'b1;
        chk_idle("bp.after", 1'b0);

        // len=7 clamps to 4 BODY flits: dst=(2,2)
        offer(2'd2, 2'd2, 3'd7, 64'h0004_0003_0002_0001);
        @(negedge clk);
        msg_valid = 1'b0;
        chk_flit("clamp.hdr", 1'b1, T_H, hdr(2, 2));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk_flit($sformatf("clamp.b%0d", k), 1'b1, T_B, 16'(k + 1));
        end
        @(negedge clk);
        chk_flit("clamp.tail", 1'b1, T_T, 16'h0000);
        @(negedge clk);
        chk_idle("clamp.done", 1'b1);

        // Self-addressed message dropped, next one accepted one cycle later
        offer(2'd1, 2'd1, 3'd2, 64'h0000_0000_00EE_00DD);
        @(negedge clk);
        chk("self.err_self", 32'(err_self), 32'd1);
        chk_idle("self.idle", 1'b0);
        offer(2'd0, 2'd1, 3'd0, 64'h0);
        @(negedge clk);
        msg_valid = 1'b0;
        chk("self.err_self_clear", 32'(err_self), 32'd0);
        chk_flit("self.next.hdr", 1'b1, T_H, hdr(0, 1));
        @(negedge clk);
        chk_flit("self.next.tail", 1'b1, T_T, 16'h0000);
        @(negedge clk);
        chk_idle("self.next.done", 1'b1);

        // Reset during BODY[1]
        offer(2'd2, 2'd3, 3'd3, 64'h0000_0007_0006_0005);
        @(negedge clk);
        msg_valid = 1'b0;
        chk_flit("rst.hdr", 1'b1, T_H, hdr(2, 3));
        @(negedge clk);
        chk_flit("rst.b0", 1'b1, T_B, 16'h0005);
        @(negedge clk);
        chk_flit("rst.b1", 1'b1, T_B, 16'h0006);
        #1 rst = 1'b1;
        #1 chk_idle("rst.async", 1'b0);
        @(negedge clk);
        rst = 1'b0;
        chk("rst.release.msg_ready", 32'(msg_ready), 32'd1);
        offer(2'd3, 2'd3, 3'd1, 64'h0000_0000_0000_0077);
        @(negedge clk);
        msg_valid = 1'b0;
        chk_flit("rst.next.hdr", 1'b1, T_H, hdr(3, 3));
        @(negedge clk);
        chk_flit("rst.next.b0", 1'b1, T_B, 16'h0077);
        @(negedge clk);
        chk_flit("rst.next.tail", 1'b1, T_T, 16'h0000);
        @(negedge clk);
        chk_idle("rst.next.done", 1'b1);

        // Back-to-back with msg_valid held high
        offer(2'd2, 2'd0, 3'd1, 64'h0000_0000_0000_00AA);
        @(negedge clk);
        offer(2'd0, 2'd3, 3'd0, 64'h0000_0000_0000_0055);
        chk_flit("b2b.a.hdr", 1'b1, T_H, hdr(2, 0));
        chk("b2b.a.hdr.msg_ready", 32'(msg_ready), 32'd0);
        @(negedge clk);
        chk_flit("b2b.a.b0", 1'b1, T_B, 16'h00AA);
        @(negedge clk);
        chk_flit("b2b.a.tail", 1'b1, T_T, 16'h0000);
        @(negedge clk);
        chk_idle("b2b.bubble", 1'b1);
        @(negedge clk);
        msg_valid = 1'b0;
        chk_flit("b2b.b.hdr", 1'b1, T_H, hdr(0, 3));
        @(negedge clk);
        chk_flit("b2b.b.tail", 1'b1, T_T, 16'h0000);
        @(negedge clk);
        chk_idle("b2b.done", 1'b1);
        @(negedge clk);
        chk_idle("b2b.quiet", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
